seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, registered successor to the team's combinational accumulator ALU. Width is configurable and outputs are registered. Integer divide and modulo run on an iterative restoring divider instead of combinational `/` and `%`. A start/busy/done handshake and status flags (zero, divide-by-zero) let the core controller issue ops and wait for completion.

Parameters:
WIDTH, 16, operand and result width in bits (>=2)
OP_W, 3, width of the operation code

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request pulse; operands and operation sampled on the clk edge where start=1 and busy=0
operation  input  OP_W  0 pass, 1 mul, 2 add, 3 sub, 4 int_div, 5 is_mod, others pass
in_bus  input  WIDTH  operand B (bus); divisor for div/mod
in_AC  input  WIDTH  operand A (accumulator); dividend for div/mod
data_out  output  WIDTH  registered result; holds until next completion
busy  output  1  high while a div/mod is iterating
done  output  1  one-cycle pulse when data_out is updated
zero  output  1  registered flag: data_out == 0, updated with data_out
div_by_zero  output  1  registered flag: last completed div/mod had in_bus == 0; cleared by any other completion

Behaviour:
- Reset (asynchronous, any time, including mid-divide): state=IDLE; data_out=0, busy=0, done=0, div_by_zero=0, zero=1. Internal divider registers cleared. No done is emitted for an aborted op.
- States: IDLE, DIV.
- Operands are latched at acceptance. Input changes afterwards have no effect on the op in flight.
- IDLE, start=1, op in {pass, mul, add, sub, undefined}:
  - On the next edge, write data_out and set done=1 for exactly one cycle.
  - Latency 1; busy stays 0.
- Arithmetic rules, all unsigned and modulo 2^WIDTH:
  - pass = B.
  - mul = low WIDTH bits of A*B.
  - add = A+B, wraps.
  - sub = A-B, wraps (0-1 = all ones).
- IDLE, start=1, op in {int_div, is_mod}, B != 0:
  - Latch A, B; clear the remainder register; set iteration counter = WIDTH; go to DIV; busy=1 from the next cycle.
- DIV, one restoring step per edge, MSB first:
  - rem = {rem, next dividend bit}.
  - If rem >= B: rem -= B and the quotient bit = 1; else the quotient bit = 0.
  - The counter decrements each step.
- Completion after the WIDTH-th step:
  - data_out = quotient (int_div) or remainder (is_mod); done=1; busy=0; return to IDLE.
  - Total latency: WIDTH cycles from the accepting edge to done high.
- Divide by zero (B == 0 at acceptance):
  - No iteration; latency 1.
  - data_out = all ones (int_div) or A (is_mod); div_by_zero=1.
- start while busy=1 is ignored (not queued); in-flight result unaffected.
- Back-to-back: start may be asserted in the same cycle done=1; the new op is accepted normally.
- done is never high in two consecutive cycles for one op. For single-cycle ops it may be high on consecutive cycles when start is held high.
- zero and div_by_zero change only on completion edges or reset.

Test Plan:
- WIDTH=16, add A=0xFFFF, B=0x0001 -> one cycle later data_out=0x0000, zero=1, done pulse 1 cycle, busy never high.
- mul A=300, B=300 -> data_out=0x5F90 (90000 mod 65536), zero=0, latency 1; sub A=0, B=1 -> 0xFFFF.
- int_div A=100, B=7 -> busy high 16 cycles, done 16 cycles after accept, data_out=0x000E; is_mod same operands -> 0x0002, div_by_zero=0.
- int_div A=5, B=0 -> next cycle data_out=0xFFFF, div_by_zero=1, busy=0; then is_mod A=5, B=0 -> data_out=0x0005, div_by_zero=1; then add 1+1 -> data_out=2, div_by_zero=0.
- Start int_div 1000/3; pulse start with add at cycle 5 -> ignored; done at cycle 16 with data_out=333; the next start in the done cycle is accepted.
- Assert rst at cycle 8 of a divide -> busy=0, data_out=0, zero=1, no done; release rst, issue pass B=0x1234 -> data_out=0x1234 after 1 cycle.
- WIDTH=8 rerun: int_div 255/16 -> data_out=15 after 8 cycles; is_mod -> 15.

Source files
------------

// File: rtl/seq_alu_if.sv
// Request/result bundle between the core controller and seq_alu.
// The controller drives operands and start; the ALU returns result, status and handshake.
interface seq_alu_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3
);
  logic             start;
  logic [OP_W-1:0]  operation;
  logic [WIDTH-1:0] in_bus;
  logic [WIDTH-1:0] in_AC;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, operation, in_bus, in_AC,
    input  data_out, busy, done, zero, div_by_zero
  );

  modport slave (
    input  start, operation, in_bus, in_AC,
    output data_out, busy, done, zero, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Registered accumulator ALU: single-cycle pass/mul/add/sub plus an iterative
// restoring divider for quotient/remainder, with start/busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [OP_W-1:0] OP_MUL = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(4);
  localparam logic [OP_W-1:0] OP_MOD = OP_W'(5);

  typedef enum logic {S_IDLE, S_DIV} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;   // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mod_q, mod_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_shift, rem_sub;
  logic             q_bit;
  logic [WIDTH-1:0] alu_res;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      mod_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b1;
      dbz_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      mod_q   <= mod_d;
      data_q  <= data_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      dbz_q   <= dbz_d;
    end
  end

  // One restoring step; a clear borrow bit means the shifted remainder was >= divisor.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    q_bit     = ~rem_sub[WIDTH];
  end

  always_comb begin
    unique case (bus.operation)
      OP_MUL:  alu_res = bus.in_AC * bus.in_bus;
      OP_ADD:  alu_res = bus.in_AC + bus.in_bus;
      OP_SUB:  alu_res = bus.in_AC - bus.in_bus;
      default: alu_res = bus.in_bus;
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    data_d  = data_q;
    done_d  = 1'b0;
    zero_d  = zero_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.operation == OP_DIV || bus.operation == OP_MOD) begin
            if (bus.in_bus == '0) begin
              data_d = (bus.operation == OP_DIV) ? '1 : bus.in_AC;
              zero_d = (bus.operation == OP_MOD) && (bus.in_AC == '0);
              dbz_d  = 1'b1;
              done_d = 1'b1;
            end else begin
              quo_d   = bus.in_AC;
              dvs_d   = bus.in_bus;
              rem_d   = '0;
              cnt_d   = CNT_W'(WIDTH);
              mod_d   = (bus.operation == OP_MOD);
              state_d = S_DIV;
            end
          end else begin
            data_d = alu_res;
            zero_d = (alu_res == '0);
            dbz_d  = 1'b0;
            done_d = 1'b1;
          end
        end
      end
      S_DIV: begin
        rem_d = q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], q_bit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          data_d  = mod_q ? rem_d : quo_d;
          zero_d  = (data_d == '0);
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.data_out    = data_q;
    bus.done        = done_q;
    bus.zero        = zero_q;
    bus.div_by_zero = dbz_q;
    bus.busy        = (state_q == S_DIV);
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus random ops on a
// 16-bit and an 8-bit instance, compared against an arithmetic reference model.
module tb_seq_alu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(16), .OP_W(3)) if16 ();
  seq_alu_if #(.WIDTH(8),  .OP_W(3)) if8  ();

  seq_alu #(.WIDTH(16), .OP_W(3)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  seq_alu #(.WIDTH(8),  .OP_W(3)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [2:0] op,
                       input logic [63:0] a, input logic [63:0] b);
    if (w == 8) begin
      if8.start = s; if8.operation = op; if8.in_AC = a[7:0]; if8.in_bus = b[7:0];
    end else begin
      if16.start = s; if16.operation = op; if16.in_AC = a[15:0]; if16.in_bus = b[15:0];
    end
  endtask

  function automatic logic [63:0] rd_data(input int w);
    return (w == 8) ? 64'(if8.data_out) : 64'(if16.data_out);
  endfunction
  function automatic logic rd_done(input int w);
    return (w == 8) ? if8.done : if16.done;
  endfunction
  function automatic logic rd_busy(input int w);
    return (w == 8) ? if8.busy : if16.busy;
  endfunction
  function automatic logic rd_zero(input int w);
    return (w == 8) ? if8.zero : if16.zero;
  endfunction
  function automatic logic rd_dbz(input int w);
    return (w == 8) ? if8.div_by_zero : if16.div_by_zero;
  endfunction

  // Reference model: plain unsigned arithmetic reduced modulo 2^w.
  function automatic logic [63:0] ref_result(input int w, input int op,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case (op)
      1:       return (a * b) & mask;
      2:       return (a + b) & mask;
      3:       return (a - b) & mask;
      4:       return (b == 0) ? mask : a / b;
      5:       return (b == 0) ? a : a % b;
      default: return b;
    endcase
  endfunction

  function automatic bit is_divop(input int op);
    return (op == 4) || (op == 5);
  endfunction

  // Issue one op, scramble the inputs right after acceptance, and check the
  // completion. 'edges' counts rising edges after the accepting edge until the
  // edge that raised done: 0 for single-cycle ops, w for an iterating divide.
  task automatic do_op(input int w, input int op, input logic [63:0] a,
                       input logic [63:0] b, input string tag);
    int          samples;
    int          busy_cnt;
    int          exp_edges;
    logic        got;
    logic [63:0] exp_res;
    @(negedge clk);
    drive(w, 1'b1, 3'(op), a, b);
    samples  = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && samples < 4 * w + 8) begin
      @(negedge clk);
      samples++;
      if (samples == 1) drive(w, 1'b0, 3'($urandom), 64'($urandom), 64'($urandom));
      if (rd_busy(w)) busy_cnt++;
      got = rd_done(w);
    end
    check({tag, " done_seen"}, 64'(got), 64'd1);
    if (got) begin
      exp_edges = (is_divop(op) && b != 0) ? w : 0;
      exp_res   = ref_result(w, op, a, b);
      check({tag, " latency"},    64'(samples - 1), 64'(exp_edges));
      check({tag, " busy_cycles"}, 64'(busy_cnt),   64'(exp_edges));
      check({tag, " data_out"},   rd_data(w),      exp_res);
      check({tag, " zero"},       64'(rd_zero(w)), 64'(exp_res == 0));
      check({tag, " div_by_zero"}, 64'(rd_dbz(w)), 64'(is_divop(op) && b == 0));
      @(negedge clk);
      check({tag, " done_pulse"}, 64'(rd_done(w)), 64'd0);
    end
  endtask

  initial begin
    int          samples;
    int          early_done;
    logic        got;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] mask;
    int          op;

    rst = 1'b1;
    drive(16, 1'b0, 3'd0, 64'd0, 64'd0);
    drive(8,  1'b0, 3'd0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    check("reset data_out", rd_data(16), 64'd0);
    check("reset zero",     64'(rd_zero(16)), 64'd1);
    check("reset busy",     64'(rd_busy(16)), 64'd0);
    check("reset done",     64'(rd_done(16)), 64'd0);
    check("reset dbz",      64'(rd_dbz(16)),  64'd0);
    check("reset8 zero",    64'(rd_zero(8)),  64'd1);
    rst = 1'b0;

    do_op(16, 2, 64'hFFFF, 64'h0001, "add_wrap");
    do_op(16, 1, 64'd300,  64'd300,  "mul_300");
    do_op(16, 3, 64'd0,    64'd1,    "sub_0m1");
    do_op(16, 4, 64'd100,  64'd7,    "div_100_7");
    do_op(16, 5, 64'd100,  64'd7,    "mod_100_7");
    do_op(16, 4, 64'd5,    64'd0,    "div_by0");
    do_op(16, 5, 64'd5,    64'd0,    "mod_by0");
    do_op(16, 2, 64'd1,    64'd1,    "add_after_dbz");
    do_op(16, 6, 64'd9,    64'h00AB, "undef_op");

    // Divide with an ignored start mid-flight, then a new op in the done cycle.
    @(negedge clk);
    drive(16, 1'b1, 3'd4, 64'd1000, 64'd3);
    samples    = 0;
    early_done = 0;
    got        = 1'b0;
    while (!got && samples < 40) begin
      @(negedge clk);
      samples++;
      got = rd_done(16);
      if (!got) begin
        if (samples == 5)      drive(16, 1'b1, 3'd2, 64'd1, 64'd1);
        else                   drive(16, 1'b0, 3'd0, 64'd0, 64'd0);
      end
    end
    check("busy_start latency", 64'(samples - 1), 64'd16);
    check("busy_start data",    rd_data(16), 64'd333);
    drive(16, 1'b1, 3'd3, 64'd10, 64'd3);
    @(negedge clk);
    drive(16, 1'b0, 3'd0, 64'd0, 64'd0);
    check("b2b done",  64'(rd_done(16)), 64'd1);
    check("b2b data",  rd_data(16), 64'd7);
    check("b2b busy",  64'(rd_busy(16)), 64'd0);

    // Reset in the middle of a divide.
    @(negedge clk);
    drive(16, 1'b1, 3'd4, 64'd1000, 64'd7);
    @(negedge clk);
    drive(16, 1'b0, 3'd0, 64'd0, 64'd0);
    repeat (7) @(negedge clk);
    check("pre_rst busy", 64'(rd_busy(16)), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst busy", 64'(rd_busy(16)), 64'd0);
    check("mid_rst data", rd_data(16), 64'd0);
    check("mid_rst zero", 64'(rd_zero(16)), 64'd1);
    check("mid_rst done", 64'(rd_done(16)), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    early_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_done(16) || rd_busy(16)) early_done++;
    end
    check("post_rst quiet", 64'(early_done), 64'd0);
    do_op(16, 0, 64'h5555, 64'h1234, "pass_after_rst");

    do_op(8, 4, 64'd255, 64'd16, "w8 div_255_16");
    do_op(8, 5, 64'd255, 64'd16, "w8 mod_255_16");
    do_op(8, 1, 64'd20,  64'd20, "w8 mul");

    mask = 64'hFFFF;
    for (int i = 0; i < 30; i++) begin
      op = int'($urandom_range(0, 7));
      a  = 64'($urandom) & mask;
      b  = ($urandom_range(0, 5) == 0) ? 64'd0 : (64'($urandom) & mask);
      do_op(16, op, a, b, "rand16");
    end
    mask = 64'hFF;
    for (int i = 0; i < 20; i++) begin
      op = int'($urandom_range(0, 7));
      a  = 64'($urandom) & mask;
      b  = ($urandom_range(0, 5) == 0) ? 64'd0 : (64'($urandom) & mask);
      do_op(8, op, a, b, "rand8");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
